alu_sequencer: RTL

Sequencing controller for the 64-bit execute-stage ALU of the Y86-64 sequential processor. It accepts one operation at a time over a valid/ready handshake, runs single-cycle ops (ADD/SUB/AND/XOR/OR) or multi-cycle iterative shifts, and returns the result over a second handshake. It owns the condition-code register (ZF, SF, OF) and provides combinational branch/cmov condition evaluation to the PC-update logic.

---
 rtl/alu_pkg.sv | 68 ++++++
 rtl/alu_sequencer_if.sv | 25 ++
 rtl/alu_core.sv | 38 +++
 rtl/alu_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the Y86-64 execute-stage ALU sequencer.
// ALU_SHIFT_EN adds the SHIFT state to the state enum.
package alu_pkg;

  localparam int DATA_W  = 64;
  localparam int SHAMT_W = 6;

  localparam logic [3:0] FUN_ADD = 4'd0;
  localparam logic [3:0] FUN_SUB = 4'd1;
  localparam logic [3:0] FUN_AND = 4'd2;
  localparam logic [3:0] FUN_XOR = 4'd3;
  localparam logic [3:0] FUN_OR  = 4'd4;
  localparam logic [3:0] FUN_SHL = 4'd5;
  localparam logic [3:0] FUN_SHR = 4'd6;
  localparam logic [3:0] FUN_SAR = 4'd7;

  localparam logic [3:0] CND_ALWAYS = 4'd0;
  localparam logic [3:0] CND_LE     = 4'd1;
  localparam logic [3:0] CND_L      = 4'd2;
  localparam logic [3:0] CND_E      = 4'd3;
  localparam logic [3:0] CND_NE     = 4'd4;
  localparam logic [3:0] CND_GE     = 4'd5;
  localparam logic [3:0] CND_G      = 4'd6;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef ALU_SHIFT_EN
    ST_SHIFT = 2'd1,
`endif
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] fun);
    return fun <= FUN_OR;
  endfunction

  function automatic logic [2:0] make_cc(input logic [DATA_W-1:0] r, input logic of);
    logic [2:0] c;
    c[CC_ZF] = (r == '0);
    c[CC_SF] = r[DATA_W-1];
    c[CC_OF] = of;
    return c;
  endfunction

  function automatic logic eval_cond(input logic [2:0] c, input logic [3:0] fun);
    logic zf, sf, of, lt;
    zf = c[CC_ZF];
    sf = c[CC_SF];
    of = c[CC_OF];
    lt = sf ^ of;
    case (fun)
      CND_ALWAYS: return 1'b1;
      CND_LE:     return lt | zf;
      CND_L:      return lt;
      CND_E:      return zf;
      CND_NE:     return ~zf;
      CND_GE:     return ~lt;
      CND_G:      return ~lt & ~zf;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between the issuing stage and the ALU sequencer.
interface alu_sequencer_if;
  import alu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_fun;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              req_set_cc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_err;

  modport master (
    output req_valid, req_fun, req_a, req_b, req_set_cc, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_fun, req_a, req_b, req_set_cc, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: result = b OP a for ADD/SUB/AND/XOR/OR,
// plus signed-overflow flag for the arithmetic ops.
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]        fun,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              of
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign sum  = b + a;
  assign diff = b - a;

  always_comb begin
    result = '0;
    of     = 1'b0;
    case (fun)
      FUN_ADD: begin
        result = sum;
        of     = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != b[DATA_W-1]);
      end
      FUN_SUB: begin
        result = diff;
        of     = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != b[DATA_W-1]);
      end
      FUN_AND: result = b & a;
      FUN_XOR: result = b ^ a;
      FUN_OR:  result = b | a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Execute-stage ALU sequencer: handshakes, FSM, iterative shifter and CC register.
// Define ALU_SHIFT_EN to build the SHL/SHR/SAR shifter; otherwise fun 5-7 are illegal.
//   state | meaning
//   IDLE  | ready for a request
//   SHIFT | iterating one bit per cycle, cnt counts down to zero
//   DONE  | response held until rsp_ready
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int W = DATA_W
)(
  input  logic             clk,
  input  logic             rst,
  alu_sequencer_if.slave   bus,
  output logic [2:0]       cc,
  input  logic [3:0]       cnd_fun,
  output logic             cnd,
  output logic             busy
);

  state_t         state, state_nx;
  logic           accept;
  logic [W-1:0]   core_result;
  logic           core_of;
  logic [W-1:0]   result_q;
  logic           err_q;
  logic [2:0]     cc_q;

`ifdef ALU_SHIFT_EN
  logic [W-1:0]       shreg, shreg_nx;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         sh_kind;
  logic               set_cc_q;
  logic               req_is_shift;

  assign req_is_shift = (bus.req_fun == FUN_SHL) || (bus.req_fun == FUN_SHR) ||
                        (bus.req_fun == FUN_SAR);
`endif

  alu_core u_core (
    .fun    (bus.req_fun),
    .a      (bus.req_a),
    .b      (bus.req_b),
    .result (core_result),
    .of     (core_of)
  );

  assign accept         = (state == ST_IDLE) && bus.req_valid;
  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.rsp_valid  = (state == ST_DONE);
  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = err_q;
  assign busy           = (state != ST_IDLE);
  assign cc             = cc_q;
  assign cnd            = eval_cond(cc_q, cnd_fun);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
`ifdef ALU_SHIFT_EN
          state_nx = req_is_shift ? ST_SHIFT : ST_DONE;
`else
          state_nx = ST_DONE;
`endif
        end
      end
`ifdef ALU_SHIFT_EN
      ST_SHIFT: if (cnt == '0) state_nx = ST_DONE;
`endif
      ST_DONE:  if (bus.rsp_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

`ifdef ALU_SHIFT_EN
  // sh_kind holds fun[1:0]: 01 SHL, 10 SHR, 11 SAR
  always_comb begin
    shreg_nx = shreg;
    case (sh_kind)
      2'b01:   shreg_nx = {shreg[W-2:0], 1'b0};
      2'b10:   shreg_nx = {1'b0, shreg[W-1:1]};
      2'b11:   shreg_nx = {shreg[W-1], shreg[W-1:1]};
      default: shreg_nx = shreg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      cnt      <= '0;
      sh_kind  <= '0;
      set_cc_q <= 1'b0;
    end else if (accept && req_is_shift) begin
      shreg    <= bus.req_b;
      cnt      <= bus.req_a[SHAMT_W-1:0];
      sh_kind  <= bus.req_fun[1:0];
      set_cc_q <= bus.req_set_cc;
    end else if (state == ST_SHIFT && cnt != '0) begin
      shreg <= shreg_nx;
      cnt   <= cnt - SHAMT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      err_q    <= 1'b0;
      cc_q     <= CC_RESET;
    end else if (accept) begin
      if (is_alu_op(bus.req_fun)) begin
        result_q <= core_result;
        err_q    <= 1'b0;
        if (bus.req_set_cc) cc_q <= make_cc(core_result, core_of);
`ifdef ALU_SHIFT_EN
      end else if (req_is_shift) begin
        err_q <= 1'b0;
`endif
      end else begin
        result_q <= '0;
        err_q    <= 1'b1;
      end
`ifdef ALU_SHIFT_EN
    end else if (state == ST_SHIFT && cnt == '0) begin
      result_q <= shreg;
      if (set_cc_q) cc_q <= make_cc(shreg, 1'b0);
`endif
    end
  end

endmodule
